// File: rtl/ipsxe_floating_point_fl2fx_pkg.sv
// ipsxe_floating_point_fl2fx_pkg: operand classes and saturation constants for the fl2fx pipe
package ipsxe_floating_point_fl2fx_pkg;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;
  function automatic int bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [127:0] max_pos(int out_w);
    return (128'(1) << (out_w - 1)) - 128'(1);
  endfunction
  function automatic logic [127:0] min_neg(int out_w);
    return 128'(1) << (out_w - 1);
  endfunction
endpackage

// File: rtl/ipsxe_floating_point_align_shifter_v1_0.sv
// ipsxe_floating_point_align_shifter_v1_0: bidirectional significand aligner; guard/sticky only with IPSXE_FL2FX_ROUND_NEAREST_EN
module ipsxe_floating_point_align_shifter_v1_0 #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int OUT_W = 32
) (
  input  logic [MAN_W:0]         sig,
  input  logic signed [EXP_W+1:0] sh,
  output logic [OUT_W:0]         mag,
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
  output logic                   guard,
  output logic                   sticky,
`endif
  output logic                   big
);
  localparam int SW = EXP_W + 2;
  localparam logic signed [SW-1:0] MW = SW'(MAN_W);
  localparam logic signed [SW-1:0] OW = SW'(OUT_W);
  localparam logic signed [SW-1:0] TOP = SW'(OUT_W - 1);
  localparam logic signed [SW-1:0] M1 = '1;
  logic [SW-1:0] lsh, rsh;
  logic [OUT_W:0] lw;
  logic [MAN_W:0] q;
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
  logic [2*MAN_W+1:0] rw;
`endif
  always_comb begin
    lsh = sh - MW;
    rsh = MW - sh;
    lw = (OUT_W+1)'(sig) << lsh;
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
    rw = {sig, (MAN_W+1)'(0)} >> rsh;
    q = rw[2*MAN_W+1 -: MAN_W+1];
    guard = sh < MW && sh >= M1 && rw[MAN_W];
    sticky = sh < M1 || (sh < MW && |rw[MAN_W-1:0]);
`else
    q = sig >> rsh;
`endif
    big = sh >= TOP;
    // at sh == OUT_W-1 the magnitude stays exact so -2^(OUT_W-1) survives
    mag = sh >= OW ? '1 : sh >= MW ? lw : sh < M1 ? '0 : (OUT_W+1)'(q);
  end
endmodule

// File: rtl/ipsxe_floating_point_fl2fx_pipe_v1_0.sv
// ipsxe_floating_point_fl2fx_pipe_v1_0: 3-stage float to fixed converter; IPSXE_FL2FX_ROUND_NEAREST_EN selects RNE over truncation
module ipsxe_floating_point_fl2fx_pipe_v1_0
  import ipsxe_floating_point_fl2fx_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [OUT_W-1:0]       o_data,
  output logic                   o_ovf,
  output logic                   o_inv
);
  localparam int SW = EXP_W + 2;
  localparam logic signed [SW-1:0] SH_OFS = SW'(FRAC_W - bias(EXP_W));
  localparam logic [OUT_W:0] MAXP = (OUT_W+1)'(max_pos(OUT_W));
  localparam logic [OUT_W:0] MINN = (OUT_W+1)'(min_neg(OUT_W));
  logic en;
  logic sgn_c;
  logic [EXP_W-1:0] exp_c;
  logic [MAN_W-1:0] man_c;
  cls_t cls_c;
  logic v1, s1_sgn;
  cls_t s1_cls;
  logic signed [SW-1:0] s1_sh;
  logic [MAN_W-1:0] s1_man;
  logic [OUT_W:0] mag;
  logic big;
  logic v2, s2_sgn, s2_big;
  cls_t s2_cls;
  logic [OUT_W:0] s2_mag;
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
  logic guard, sticky, s2_g, s2_s;
`endif
  logic rnd, over, ovf_c, inv_c;
  logic [OUT_W:0] rm;
  logic [OUT_W-1:0] sat, data_c;
  assign en = !o_valid || i_ready;
  assign o_ready = en;
  assign {sgn_c, exp_c, man_c} = i_data;
  always_comb cls_c = exp_c == '0 ? ZERO : exp_c != '1 ? NORM : man_c == '0 ? INF : NAN;
  ipsxe_floating_point_align_shifter_v1_0 #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .OUT_W(OUT_W)
  ) u_align (
    .sig({1'b1, s1_man}),
    .sh(s1_sh),
    .mag(mag),
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
    .guard(guard),
    .sticky(sticky),
`endif
    .big(big)
  );
  always_comb begin
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
    rnd = s2_g && (s2_s || s2_mag[0]);
`else
    rnd = 1'b0;
`endif
    rm = s2_mag + (OUT_W+1)'(rnd);
    sat = s2_sgn ? MINN[OUT_W-1:0] : MAXP[OUT_W-1:0];
    over = s2_sgn ? rm > MINN : s2_big || rm > MAXP;
    data_c = (s2_cls == NAN || s2_cls == ZERO) ? '0 : (s2_cls == INF || over) ? sat : s2_sgn ? -rm[OUT_W-1:0] : rm[OUT_W-1:0];
    ovf_c = s2_cls == INF || (s2_cls == NORM && over);
    inv_c = s2_cls == NAN;
  end
  always_ff @(posedge i_clk) begin
    if (en) begin
      s1_sgn <= sgn_c;
      s1_cls <= cls_c;
      s1_sh <= SW'(exp_c) + SH_OFS;
      s1_man <= man_c;
      s2_sgn <= s1_sgn;
      s2_cls <= s1_cls;
      s2_mag <= mag;
      s2_big <= big;
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
      s2_g <= guard;
      s2_s <= sticky;
`endif
    end
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_ovf <= 1'b0;
      o_inv <= 1'b0;
    end else if (en) begin
      v1 <= i_valid;
      v2 <= v1;
      o_valid <= v2;
      o_data <= data_c;
      o_ovf <= ovf_c;
      o_inv <= inv_c;
    end
  end
endmodule

// File: tb/tb_ipsxe_floating_point_fl2fx_pipe_v1_0.sv
// tb_ipsxe_floating_point_fl2fx_pipe_v1_0: scoreboard bench with directed float vectors for both rounding builds
module tb_ipsxe_floating_point_fl2fx_pipe_v1_0;
`ifdef IPSXE_FL2FX_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  typedef struct { logic [31:0] f; logic [31:0] d; logic ovf; logic inv; } vec_t;
  typedef struct { logic [33:0] r; int cyc; } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic iv_a = 1'b0, ir_a = 1'b1, iv_b = 1'b0, ir_b = 1'b1;
  logic [31:0] id_a = '0, id_b = '0;
  logic or_a, ov_a, ovf_a, inv_a, or_b, ov_b, ovf_b, inv_b;
  logic [31:0] od_a, od_b;
  bit rnd_rdy = 1'b0, lat_chk = 1'b0;
  int n_cmp = 0, n_bad = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  vec_t tv[24];
  vec_t v8[4];

  ipsxe_floating_point_fl2fx_pipe_v1_0 dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(iv_a), .o_ready(or_a), .i_data(id_a),
    .o_valid(ov_a), .i_ready(ir_a), .o_data(od_a), .o_ovf(ovf_a), .o_inv(inv_a)
  );
  ipsxe_floating_point_fl2fx_pipe_v1_0 #(.FRAC_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(iv_b), .o_ready(or_b), .i_data(id_b),
    .o_valid(ov_b), .i_ready(ir_b), .o_data(od_b), .o_ovf(ovf_b), .o_inv(inv_b)
  );

  always @(posedge clk) begin
    #1;
    ir_a = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_extra: got unexpected word %h want none (cycle %0d)", od_a, cyc);
      end else if (ir_a) begin
        ea = qa.pop_front();
        chk("a_out", 64'({od_a, ovf_a, inv_a}), 64'(ea.r));
        if (lat_chk) chk("a_latency", 64'(cyc - ea.cyc), 64'd3);
      end else chk("a_stall", 64'({od_a, ovf_a, inv_a}), 64'(qa[0].r));
    end
    if (!rst && ov_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_extra: got unexpected word %h want none (cycle %0d)", od_b, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_out", 64'({od_b, ovf_b, inv_b}), 64'(eb.r));
        chk("b_latency", 64'(cyc - eb.cyc), 64'd3);
      end
    end
  end

  task automatic send(input bit b, input vec_t v);
    exp_t e;
    if (b) begin iv_b = 1'b1; id_b = v.f; end
    else begin iv_a = 1'b1; id_a = v.f; end
    @(negedge clk);
    for (int i = 0; i < 100 && !(b ? or_b : or_a); i++) @(negedge clk);
    if (!(b ? or_b : or_a)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept: o_ready got 0 want 1 after 100 cycles");
    end else begin
      e.r = {v.d, v.ovf, v.inv};
      e.cyc = cyc;
      if (b) qb.push_back(e);
      else qa.push_back(e);
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (qa.size() + qb.size()) != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{32'h3FC00000, RNE ? 32'h00000002 : 32'h00000001, 1'b0, 1'b0};
    tv[1]  = '{32'h40200000, 32'h00000002, 1'b0, 1'b0};
    tv[2]  = '{32'hC0700000, RNE ? 32'hFFFFFFFC : 32'hFFFFFFFD, 1'b0, 1'b0};
    tv[3]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0};
    tv[4]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0};
    tv[5]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0};
    tv[6]  = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1};
    tv[7]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b0};
    tv[8]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0};
    tv[9]  = '{32'h3F400000, RNE ? 32'h00000001 : 32'h00000000, 1'b0, 1'b0};
    tv[10] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0};
    tv[11] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0};
    tv[12] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0};
    tv[13] = '{32'h3E800000, 32'h00000000, 1'b0, 1'b0};
    tv[14] = '{32'hBF400000, RNE ? 32'hFFFFFFFF : 32'h00000000, 1'b0, 1'b0};
    tv[15] = '{32'h447A0000, 32'h000003E8, 1'b0, 1'b0};
    tv[16] = '{32'h3FE00000, RNE ? 32'h00000002 : 32'h00000001, 1'b0, 1'b0};
    tv[17] = '{32'h40600000, RNE ? 32'h00000004 : 32'h00000003, 1'b0, 1'b0};
    tv[18] = '{32'hBFC00000, RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b0, 1'b0};
    tv[19] = '{32'h7F800001, 32'h00000000, 1'b0, 1'b1};
    tv[20] = '{32'hD0000000, 32'h80000000, 1'b1, 1'b0};
    tv[21] = '{32'h4F800000, 32'h7FFFFFFF, 1'b1, 1'b0};
    tv[22] = '{32'h3F000000, 32'h00000000, 1'b0, 1'b0};
    tv[23] = '{32'h807FFFFF, 32'h00000000, 1'b0, 1'b0};
    v8[0]  = '{32'h3F800000, 32'h00000100, 1'b0, 1'b0};
    v8[1]  = '{32'h3FC00000, 32'h00000180, 1'b0, 1'b0};
    v8[2]  = '{32'hC0700000, 32'hFFFFFC40, 1'b0, 1'b0};
    v8[3]  = '{32'h3B800000, 32'h00000001, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_a", 64'({ov_a, od_a, ovf_a, inv_a}), 64'd0);
    chk("reset_b", 64'({ov_b, od_b, ovf_b, inv_b}), 64'd0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    foreach (tv[i]) send(1'b0, tv[i]);
    foreach (v8[i]) send(1'b1, v8[i]);
    drain();
    lat_chk = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b0, tv[i]);
    drain();
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(1'b0, tv[15]);
    send(1'b0, tv[11]);
    send(1'b0, tv[2]);
    rst = 1'b1;
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flush", 64'({ov_a, od_a, ovf_a, inv_a}), 64'd0);
    @(posedge clk);
    #1;
    send(1'b0, tv[17]);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
